// File: rtl/sha3_pkg.sv
// Shared constants, state type and helpers for the SHA-3 absorb front-end.
// Rate constants are given in 64-bit words per SHA-3 output size.
package sha3_pkg;

  localparam int SHA3_WORD_W         = 64;
  localparam int SHA3_BYTES_PER_WORD = 8;

  localparam logic [7:0] SHA3_DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] SHA3_DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] SHA3_PAD_END      = 8'h80;

  localparam int SHA3_224_RATE_WORDS = 18;
  localparam int SHA3_256_RATE_WORDS = 17;
  localparam int SHA3_384_RATE_WORDS = 13;
  localparam int SHA3_512_RATE_WORDS = 9;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    OUT  = 2'd1,
    PAD  = 2'd2
  } sha3_state_t;

  // A final word can never carry more than a full word of message bytes.
  function automatic logic [3:0] sha3_clamp_nbytes(input logic [3:0] nbytes);
    return (nbytes > 4'd8) ? 4'd8 : nbytes;
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational padding of one 64-bit word: keeps bytes below i_nbytes,
// writes the domain byte at i_nbytes, zeroes the rest and optionally ORs 0x80 into byte 7.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [SHA3_WORD_W-1:0] i_data,
  input  logic [3:0]             i_nbytes,
  input  logic [7:0]             i_domain,
  input  logic                   i_set_end,
  output logic [SHA3_WORD_W-1:0] o_word
);

  genvar gi;
  generate
    for (gi = 0; gi < SHA3_BYTES_PER_WORD; gi++) begin : g_byte
      logic [7:0] w_byte;

      always_comb begin
        w_byte = 8'h00;
        if (4'(gi) < i_nbytes) begin
          w_byte = i_data[8*gi +: 8];
        end else if (4'(gi) == i_nbytes) begin
          w_byte = i_domain;
        end
      end

      // Byte 7 may carry both the domain byte and the end marker (0x86 for SHA-3).
      if (gi == SHA3_BYTES_PER_WORD - 1) begin : g_end
        assign o_word[8*gi +: 8] = w_byte | (i_set_end ? SHA3_PAD_END : 8'h00);
      end else begin : g_mid
        assign o_word[8*gi +: 8] = w_byte;
      end
    end
  endgenerate

endmodule

// File: rtl/sha3_absorb_padder.sv
// SHA-3/SHAKE absorb front-end: packs 64-bit message words into rate-sized padded blocks.
// Optional macro SHA3_MSG_LEN_EN adds the msg_bytes running byte counter output.
module sha3_absorb_padder
  import sha3_pkg::*;
#(
  parameter int         RATE_WORDS = SHA3_512_RATE_WORDS,
  parameter logic [7:0] DOMAIN     = SHA3_DOMAIN_SHA3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SHA3_WORD_W-1:0]            in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic [3:0]                        in_nbytes,
  output logic                              in_ready,
  output logic [SHA3_WORD_W*RATE_WORDS-1:0] blk_data,
  output logic                              blk_valid,
  output logic                              blk_last,
  input  logic                              blk_ready
`ifdef SHA3_MSG_LEN_EN
  ,
  output logic [63:0]                       msg_bytes
`endif
);

  localparam int              IDX_W    = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

  sha3_state_t r_state;
  sha3_state_t w_state_next;

  logic [RATE_WORDS-1:0][SHA3_WORD_W-1:0] r_buf;
  logic [IDX_W-1:0]                       r_idx;
  logic                                   r_last;
  logic                                   r_pend;

  logic                   w_accept;
  logic                   w_handoff;
  logic                   w_at_end;
  logic                   w_full_last;
  logic [3:0]             w_nbytes;
  logic [3:0]             w_pad_nbytes;
  logic                   w_pad_end;
  logic [SHA3_WORD_W-1:0] w_word;

  assign w_accept     = in_valid & in_ready;
  assign w_handoff    = blk_valid & blk_ready;
  assign w_at_end     = (r_idx == LAST_IDX);
  assign w_nbytes     = sha3_clamp_nbytes(in_nbytes);
  assign w_full_last  = in_last & (w_nbytes == 4'd8);
  assign w_pad_nbytes = in_last ? w_nbytes : 4'd8;
  assign w_pad_end    = in_last & ~w_full_last & w_at_end;

  sha3_pad_word u_pad_word (
    .i_data    (in_data),
    .i_nbytes  (w_pad_nbytes),
    .i_domain  (DOMAIN),
    .i_set_end (w_pad_end),
    .o_word    (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (w_accept && (in_last || w_at_end)) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        if (blk_ready) begin
          w_state_next = r_pend ? PAD : FILL;
        end
      end
      PAD:     w_state_next = OUT;
      default: w_state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == FILL);
    blk_valid = (r_state == OUT);
  end

  // Untouched buffer bytes stay zero because the buffer is cleared on every handoff,
  // so the end marker and domain byte can simply be written rather than ORed in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_buf[r_idx] <= w_word;
            r_idx        <= r_idx + 1'b1;
            if (!in_last) begin
              r_last <= 1'b0;
            end else if (!w_full_last) begin
              r_last <= 1'b1;
              if (!w_at_end) begin
                r_buf[RATE_WORDS-1][63:56] <= SHA3_PAD_END;
              end
            end else if (!w_at_end) begin
              r_last                     <= 1'b1;
              r_buf[r_idx + 1'b1][7:0]   <= DOMAIN;
              r_buf[RATE_WORDS-1][63:56] <= SHA3_PAD_END;
            end else begin
              // Message ended exactly on a block boundary: padding needs its own block.
              r_last <= 1'b0;
              r_pend <= 1'b1;
            end
          end
        end
        OUT: begin
          if (blk_ready) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_last <= 1'b0;
          end
        end
        PAD: begin
          r_buf[0][7:0]              <= DOMAIN;
          r_buf[RATE_WORDS-1][63:56] <= SHA3_PAD_END;
          r_last                     <= 1'b1;
          r_pend                     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign blk_last = r_last;

  genvar gi;
  generate
    for (gi = 0; gi < RATE_WORDS; gi++) begin : g_blk
      assign blk_data[SHA3_WORD_W*gi +: SHA3_WORD_W] = r_buf[gi];
    end
  endgenerate

`ifdef SHA3_MSG_LEN_EN
  logic [63:0] r_msg_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg_bytes <= '0;
    end else if (w_handoff && r_last) begin
      r_msg_bytes <= '0;
    end else if (w_accept) begin
      r_msg_bytes <= r_msg_bytes + 64'(w_pad_nbytes);
    end
  end

  assign msg_bytes = r_msg_bytes;
`else
  logic w_unused;
  assign w_unused = w_handoff;
`endif

endmodule

// File: tb/tb_sha3_absorb_padder.sv
// Directed bench for sha3_absorb_padder: a byte-level pad10*1 model predicts every block,
// with literal expectations for the classic vectors.
`timescale 1ns/1ps
module tb_sha3_absorb_padder;
  import sha3_pkg::*;

  localparam int         R   = 9;
  localparam int         RB  = R * 8;
  localparam int         W   = 64 * R;
  localparam logic [7:0] DOM = 8'h06;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [W-1:0]    data;
    bit              last;
    longint unsigned len;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [3:0]   in_nbytes;
  logic         in_ready;
  logic [W-1:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;
`ifdef SHA3_MSG_LEN_EN
  logic [63:0]  msg_bytes;
`endif

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sha3_absorb_padder #(.RATE_WORDS(R), .DOMAIN(DOM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
`ifdef SHA3_MSG_LEN_EN
    ,
    .msg_bytes (msg_bytes)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Standard SHA-3 padding on the byte string: msg || DOMAIN || 0* || 0x80 (last byte).
  function automatic void model_push(input bq_t m);
    int   n;
    int   total;
    bq_t  p;
    blk_t b;
    n     = m.size();
    total = (n / RB + 1) * RB;
    p     = m;
    p.push_back(DOM);
    while (p.size() < total) p.push_back(8'h00);
    p[total-1] = p[total-1] | 8'h80;
    for (int k = 0; k < total / RB; k++) begin
      b.data = '0;
      for (int i = 0; i < RB; i++) b.data[8*i +: 8] = p[k*RB + i];
      b.last = (k == total / RB - 1);
      b.len  = longint'(n);
      exp_q.push_back(b);
    end
  endfunction

  function automatic bq_t mk_msg(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'((seed * 31 + i * 7 + 3) & 255));
    return q;
  endfunction

  // Called at a negedge; in_ready only changes on posedge, so its value now decides acceptance.
  task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb, output int cyc);
    bit done;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    cyc       = 0;
    done      = 1'b0;
    while (!done && cyc < 200) begin
      cyc++;
      done = in_ready;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout got=no_accept want=accept");
    end
  endtask

  task automatic send_msg(input bq_t m, input int nb_field, output int first_cyc);
    int          n;
    int          nw;
    int          cyc;
    bit          last;
    logic [63:0] d;
    logic [3:0]  nb;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    model_push(m);
    first_cyc = 0;
    for (int w = 0; w < nw; w++) begin
      last = (w == nw - 1);
      for (int i = 0; i < 8; i++)
        d[8*i +: 8] = (8*w + i < n) ? m[8*w + i] : (8'hA5 ^ 8'(i));
      if (!last)              nb = 4'd3;
      else if (nb_field >= 0) nb = 4'(nb_field);
      else                    nb = 4'(n - 8*w);
      send_word(d, last, nb, cyc);
      if (w == 0) first_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!blk_valid) begin
      errors++;
      $display("FAIL %s got=no_blk_valid want=blk_valid", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got=%0d_pending want=0", name, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && blk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block got=%0h want=none", blk_data);
      end else begin
        chk("blk_data", blk_data, exp_q[0].data);
        chk("blk_last", W'(blk_last), W'(exp_q[0].last));
        chk("in_ready_during_out", W'(in_ready), '0);
`ifdef SHA3_MSG_LEN_EN
        if (exp_q[0].last) chk("msg_bytes", W'(msg_bytes), W'(exp_q[0].len));
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && blk_valid && blk_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  initial begin
    bq_t m;
    int  fc;
    int  cyc;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = '0;
    blk_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_blk_valid", W'(blk_valid), '0);
    chk("rst_blk_last", W'(blk_last), '0);
    rst = 1'b0;
    @(negedge clk);

    m.delete();
    send_msg(m, -1, fc);
    wait_valid("empty");
    chk("empty_w0", W'(blk_data[63:0]), W'(64'h0000000000000006));
    chk("empty_w8", W'(blk_data[575:512]), W'(64'h8000000000000000));
    chk("empty_mid", W'(blk_data[511:64]), '0);
    chk("empty_last", W'(blk_last), W'(1'b1));
    wait_drain("empty");

    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    send_msg(m, -1, fc);
    wait_valid("abc");
    chk("abc_w0", W'(blk_data[63:0]), W'(64'h0000000006636261));
    chk("abc_w8", W'(blk_data[575:512]), W'(64'h8000000000000000));
    wait_drain("abc");

    send_msg(mk_msg(71, 1), -1, fc);
    wait_valid("len71");
    chk("len71_byte575", W'(blk_data[575:568]), W'(8'h86));
    chk("len71_last", W'(blk_last), W'(1'b1));
    wait_drain("len71");

    send_msg(mk_msg(72, 2), -1, fc);
    wait_valid("len72_b1");
    chk("len72_b1_last", W'(blk_last), '0);
    @(negedge clk);
    chk("pad_bubble_valid", W'(blk_valid), '0);
    chk("pad_bubble_ready", W'(in_ready), '0);
    @(negedge clk);
    chk("len72_b2_valid", W'(blk_valid), W'(1'b1));
    chk("len72_b2_last", W'(blk_last), W'(1'b1));
    chk("len72_b2_w0", W'(blk_data[63:0]), W'(64'h0000000000000006));
    chk("len72_b2_w8", W'(blk_data[575:512]), W'(64'h8000000000000000));
    wait_drain("len72");

    send_msg(mk_msg(8, 3), -1, fc);   wait_drain("len8");
    send_msg(mk_msg(64, 4), -1, fc);  wait_drain("len64");
    send_msg(mk_msg(80, 5), -1, fc);  wait_drain("len80");
    send_msg(mk_msg(150, 6), -1, fc); wait_drain("len150");
    send_msg(mk_msg(8, 7), 12, fc);   wait_drain("nbytes12");

    blk_ready = 1'b0;
    send_msg(mk_msg(5, 8), -1, fc);
    wait_valid("stall");
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", W'(blk_valid), W'(1'b1));
      chk("stall_in_ready", W'(in_ready), '0);
      chk("stall_last", W'(blk_last), W'(1'b1));
      @(negedge clk);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", W'(in_ready), W'(1'b1));
    send_msg(mk_msg(6, 9), -1, fc);
    chk("accept_after_handoff", W'(fc), W'(1));
    wait_drain("stall");

    blk_ready = 1'b0;
    send_msg(mk_msg(10, 10), -1, fc);
    wait_valid("rst_out");
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_out_valid", W'(blk_valid), '0);
    chk("rst_out_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_out_last", W'(blk_last), '0);
    @(negedge clk);
    rst       = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 4; w++) send_word(64'hDEAD_BEEF_0000_0000 | 64'(w), 1'b0, 4'd0, cyc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_mid_valid", W'(blk_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    send_msg(m, -1, fc);
    wait_valid("abc2");
    chk("abc2_w0", W'(blk_data[63:0]), W'(64'h0000000006636261));
    chk("abc2_mid", W'(blk_data[511:64]), '0);
    chk("abc2_w8", W'(blk_data[575:512]), W'(64'h8000000000000000));
    chk("abc2_last", W'(blk_last), W'(1'b1));
    wait_drain("abc2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha3_absorb_padder.md
Name: sha3_absorb_padder

Overview:
- Message front-end feeding the sequential Keccak-f core.
- Accepts a little-endian 64-bit word stream and applies SHA-3/SHAKE multi-rate padding.
- Assembles rate-sized blocks and hands each to the permutation side with a valid/ready handshake.
- Default rate is 576 bits (9 words), the width of the core's {e_init, g_init} input; blk_data[287:0] maps to g_init and blk_data[575:288] to e_init.

Parameters:
RATE_WORDS, 9, rate in 64-bit words (9=SHA3-512, 17=SHA3-256); legal range 2..21
DOMAIN, 8'h06, domain-separation byte (8'h06 SHA-3, 8'h1F SHAKE)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_data  input  64  message word; byte i at bits [8i+7:8i]
in_valid  input  1  in_data valid
in_last  input  1  final word of message
in_nbytes  input  4  valid bytes in final word, 0..8; ignored unless in_last
in_ready  output  1  word accepted when in_valid & in_ready
blk_data  output  64*RATE_WORDS  padded block; word k at [64k+63:64k]
blk_valid  output  1  block available
blk_last  output  1  block is final (padding included)
blk_ready  input  1  block consumed when blk_valid & blk_ready

Behaviour:
- Reset (async, immediate): state FILL, word index 0, buffer all zero, blk_valid=0, blk_last=0, in_ready=1; any partial message is discarded.
- States: FILL, OUT, PAD.
- FILL: in_ready=1, blk_valid=0. On an accepted word, write to buffer word idx, then idx++.
  - Not last, idx<RATE_WORDS-1: stay in FILL.
  - Not last, idx=RATE_WORDS-1: go to OUT, blk_last=0.
  - Last, nbytes<8: keep bytes 0..nbytes-1, zero bytes above, place DOMAIN at byte nbytes. If idx=RATE_WORDS-1, OR 8'h80 into byte 7 of that word; otherwise OR 8'h80 into byte 7 of word RATE_WORDS-1. Coinciding bytes yield DOMAIN|8'h80 (8'h86 for SHA-3). Go to OUT, blk_last=1.
  - Last, nbytes=8, idx<RATE_WORDS-1: word written unchanged; DOMAIN into byte 0 of word idx+1; 8'h80 OR'd into byte 7 of word RATE_WORDS-1. Go to OUT, blk_last=1.
  - Last, nbytes=8, idx=RATE_WORDS-1: go to OUT, blk_last=0, with a pending-pad flag set.
  - nbytes>8 on a last word is illegal; treated as 8.
- OUT: blk_valid=1, in_ready=0. blk_data and blk_last are held stable until the handshake.
  - On handshake: buffer cleared to zero, idx=0.
  - Next state is PAD if pending-pad is set, else FILL.
- PAD (1 cycle, in_ready=0): buffer word0 byte0=DOMAIN, word RATE_WORDS-1 byte 7=8'h80, blk_last=1, clear pending-pad, go to OUT.
- Latency:
  - blk_valid rises the cycle after the accepting edge of the filling word.
  - Next in_ready rises the cycle after the block handshake.
  - Throughput: one word per cycle while filling, plus 1 bubble per block.
- Unpadded buffer bytes are always zero because the buffer is cleared on each handoff.
- in_valid while in_ready=0 is ignored; upstream holds data.
- blk_ready while blk_valid=0 has no effect.

Optional Feature:
- Macro SHA3_MSG_LEN_EN.
- Defined:
  - Adds output msg_bytes[63:0]: running count of accepted message bytes (8 per non-last word, nbytes for the last word).
  - Value is stable while blk_valid & blk_last; counter clears on the final-block handshake and on reset.
  - Count wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sha3_pkg:
  - constants SHA3_WORD_W=64, SHA3_DOMAIN_SHA3=8'h06, SHA3_DOMAIN_SHAKE=8'h1F, SHA3_PAD_END=8'h80;
  - state enum {FILL, OUT, PAD};
  - rate constants for 224/256/384/512.
- One combinational sub-module, sha3_pad_word: (data, nbytes, domain, set_end) -> padded 64-bit word; it does byte masking, domain insertion and the 0x80 OR.

Test Plan:
- Empty message (last, nbytes=0) -> one block, word0=64'h06, word8=64'h8000000000000000, other words 0, blk_last=1.
- "abc" (in_data=64'h636261, last, nbytes=3) -> word0=64'h0000000006636261, word8=64'h8000000000000000, blk_last=1.
- 71-byte message (9 words, last nbytes=7) -> single block, word8 byte7=8'h86, blk_last=1.
- 72-byte message -> block 1 holds data, blk_last=0; block 2 has word0=64'h06, word8=64'h8000000000000000, blk_last=1; exactly one PAD cycle between blocks.
- blk_ready held low 5 cycles in OUT -> blk_data/blk_valid/blk_last stable, in_ready=0 throughout; word accepted the cycle after handoff.
- rst asserted after 4 words of a message -> outputs return to reset values immediately; a fresh "abc" message yields the block from the "abc" case.
